fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control unit and datapath decode.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Registers the returned instruction and presents it, pre-split into op/funct3/funct7 and register fields, to decode through a valid/ready handshake.
- Computes the next PC from the PCSrc/PCTarget that the control unit and datapath produce for the instruction being consumed.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_pc_reg.sv | 37 +++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state type, instruction width, the reset NOP encoding and
// the bit positions of the fields that decode consumes.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;

    localparam int unsigned OP_LSB  = 0;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned F3_LSB  = 12;
    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned F7_LSB  = 25;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pc <= RESET_PC)
//   load       : advance the PC this cycle
//   take       : select the redirect target instead of pc+4
//   target     : redirect target; bits [1:0] are dropped
//   pc         : current PC
module fetch_pc_reg #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              take,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_nxt;
    logic              unused_target_lsbs;

    // Targets are forced word-aligned; the low bits are discarded silently.
    assign unused_target_lsbs = ^target[1:0];

    // Sequential advance wraps modulo 2^ADDR_W.
    assign pc_nxt = take ? {target[ADDR_W-1:2], 2'b00} : pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding fetch from instruction memory,
// registered instruction presented to decode through valid/ready, next PC
// chosen from PCSrc/PCTarget when decode consumes the instruction.
// Optional macro FETCH_PERF_CNT_EN adds perf_instr_cnt / perf_stall_cnt.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata         : instruction-memory request/response
//   id_valid, id_ready              : handshake towards decode
//   instr, op, funct3, funct7,
//   rd, rs1, rs2, id_pc             : instruction register and its fields
//   PCSrc, PCTarget                 : redirect, sampled on handshake only
//   perf_instr_cnt, perf_stall_cnt  : (FETCH_PERF_CNT_EN) event counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [OP_W-1:0]    op,
    output logic [F3_W-1:0]    funct3,
    output logic [F7_W-1:0]    funct7,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [ADDR_W-1:0]  id_pc,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  PCTarget
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_instr_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_t      state, state_nxt;
    logic              instr_load;
    logic              pc_load;
    logic [ADDR_W-1:0] pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and load strobes
    always_comb begin
        state_nxt  = state;
        instr_load = 1'b0;
        pc_load    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    instr_load = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (id_ready) begin
                    pc_load   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Request is a direct state decode, so it is already high during reset.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .take   (PCSrc),
        .target (PCTarget),
        .pc     (pc)
    );

    // Instruction register and the PC it was fetched from
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            id_pc <= RESET_PC;
        end else if (instr_load) begin
            instr <= imem_rdata;
            id_pc <= pc;
        end
    end

    // Valid flag: set on fetch return, cleared on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
        end else if (instr_load) begin
            id_valid <= 1'b1;
        end else if (pc_load) begin
            id_valid <= 1'b0;
        end
    end

    assign op     = instr[OP_LSB  +: OP_W];
    assign rd     = instr[RD_LSB  +: REG_W];
    assign funct3 = instr[F3_LSB  +: F3_W];
    assign rs1    = instr[RS1_LSB +: REG_W];
    assign rs2    = instr[RS2_LSB +: REG_W];
    assign funct7 = instr[F7_LSB  +: F7_W];

`ifdef FETCH_PERF_CNT_EN
    logic instr_evt;
    logic stall_evt;

    assign instr_evt = id_valid & id_ready;
    // Memory wait in FETCH or decode back-pressure in HOLD
    assign stall_evt = ((state == FETCH) & ~imem_ack) | ((state == HOLD) & ~id_ready);

    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (instr_evt) perf_instr_cnt <= perf_instr_cnt + 32'd1;
            if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a primary instance with
// RESET_PC=0 and a second instance with RESET_PC=32'hFFFF_FFFC for PC wrap.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_ack, id_ready, pcsrc;
    logic [31:0] imem_rdata, pctarget;
    logic        imem_req, id_valid;
    logic [31:0] imem_addr, instr, id_pc;
    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_instr_cnt, perf_stall_cnt;
    logic [31:0] w_perf_instr_cnt, w_perf_stall_cnt;
`endif

    logic        w_ack, w_ready, w_pcsrc;
    logic [31:0] w_rdata, w_pctarget;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_id_pc;
    logic [6:0]  w_op, w_funct7;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd, w_rs1, w_rs2;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .instr(instr), .op(op), .funct3(funct3),
        .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .id_pc(id_pc),
        .PCSrc(pcsrc), .PCTarget(pctarget)
`ifdef FETCH_PERF_CNT_EN
        , .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .id_valid(w_valid), .id_ready(w_ready), .instr(w_instr), .op(w_op), .funct3(w_funct3),
        .funct7(w_funct7), .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2), .id_pc(w_id_pc),
        .PCSrc(w_pcsrc), .PCTarget(w_pctarget)
`ifdef FETCH_PERF_CNT_EN
        , .perf_instr_cnt(w_perf_instr_cnt), .perf_stall_cnt(w_perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch at exp_addr with immediate ack, then consume with immediate ready.
    task automatic fetch_consume(input logic [31:0] exp_addr, input logic [31:0] word,
                                 input logic src, input logic [31:0] tgt);
        check("fc_addr", imem_addr, exp_addr);
        check("fc_req", 32'(imem_req), 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack = 1'b0;
        check("fc_valid", 32'(id_valid), 32'd1);
        check("fc_id_pc", id_pc, exp_addr);
        check("fc_instr", instr, word);
        id_ready = 1'b1;
        pcsrc    = src;
        pctarget = tgt;
        tick();
        id_ready = 1'b0;
        pcsrc    = 1'b0;
        pctarget = 32'h0;
        check("fc_valid_clr", 32'(id_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0; pcsrc = 1'b0; pctarget = 32'h0;
        w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0; w_pcsrc = 1'b0; w_pctarget = 32'h0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_op", 32'(op), 32'h13);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

        // First fetch: addi x1, x0, 5
        rst_n = 1'b1;
        check("f1_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'h0050_0093;
        tick();
        imem_ack = 1'b0;
        check("f1_valid", 32'(id_valid), 32'd1);
        check("f1_op", 32'(op), 32'h13);
        check("f1_rd", 32'(rd), 32'd1);
        check("f1_funct3", 32'(funct3), 32'd0);
        check("f1_id_pc", id_pc, 32'h0);
        check("f1_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;

        // Sequential flow, then a taken branch with misaligned target at id_pc=8
        fetch_consume(32'h4, 32'h0010_0113, 1'b0, 32'h0);
        fetch_consume(32'h8, 32'h0000_0063, 1'b1, 32'h0000_0041);
        check("br_addr", imem_addr, 32'h0000_0040);

        // Back-pressure: sub x3, x1, x2 held for 5 cycles while PCSrc toggles
        imem_ack = 1'b1;
        imem_rdata = 32'h4020_81B3;
        tick();
        imem_ack = 1'b0;
        check("bp_op", 32'(op), 32'h33);
        check("bp_rd", 32'(rd), 32'd3);
        check("bp_rs1", 32'(rs1), 32'd1);
        check("bp_rs2", 32'(rs2), 32'd2);
        check("bp_funct7", 32'(funct7), 32'h20);
        for (int i = 0; i < 5; i++) begin
            pcsrc = i[0];
            pctarget = 32'h0000_0100;
            tick();
            check("bp_valid", 32'(id_valid), 32'd1);
            check("bp_req", 32'(imem_req), 32'd0);
            check("bp_instr", instr, 32'h4020_81B3);
            check("bp_id_pc", id_pc, 32'h0000_0040);
            check("bp_addr", imem_addr, 32'h0000_0040);
        end
        pcsrc = 1'b0;
        pctarget = 32'h0;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("bp_next_addr", imem_addr, 32'h0000_0044);

        // Memory stall: ack delayed 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ms_addr", imem_addr, 32'h0000_0044);
            check("ms_req", 32'(imem_req), 32'd1);
        end
        fetch_consume(32'h44, 32'h0020_8233, 1'b0, 32'h0);

        // Ack and rdata changes while in HOLD are ignored
        imem_ack = 1'b1;
        imem_rdata = 32'h1111_1111;
        tick();
        imem_rdata = 32'h2222_2222;
        repeat (2) tick();
        check("hold_ack_instr", instr, 32'h1111_1111);
        check("hold_ack_id_pc", id_pc, 32'h0000_0048);
        imem_ack = 1'b0;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("hold_ack_addr", imem_addr, 32'h0000_004C);

        // PC wrap on the second instance
        check("wr_addr", w_addr, 32'hFFFF_FFFC);
        w_ack = 1'b1;
        w_rdata = 32'h0000_0013;
        tick();
        w_ack = 1'b0;
        check("wr_id_pc", w_id_pc, 32'hFFFF_FFFC);
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        check("wr_next_addr", w_addr, 32'h0);

        // Asynchronous reset mid-HOLD
        imem_ack = 1'b1;
        imem_rdata = 32'h0030_0193;
        tick();
        imem_ack = 1'b0;
        check("ar_pre_valid", 32'(id_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(id_valid), 32'd0);
        check("ar_addr", imem_addr, 32'h0);
        check("ar_req", 32'(imem_req), 32'd1);
        check("ar_instr", instr, 32'h0000_0013);
        tick();
        // Stale ack present in the first cycle after release is taken as the RESET_PC fetch
        imem_ack = 1'b1;
        imem_rdata = 32'h0070_0393;
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("ar_stale_valid", 32'(id_valid), 32'd1);
        check("ar_stale_id_pc", id_pc, 32'h0);
        check("ar_stale_instr", instr, 32'h0070_0393);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        check("ar_next_addr", imem_addr, 32'h4);

`ifdef FETCH_PERF_CNT_EN
        // Counters: 4 instructions, each with 2 memory-stall cycles
        rst_n = 1'b0;
        tick();
        check("pc_rst_instr", perf_instr_cnt, 32'd0);
        check("pc_rst_stall", perf_stall_cnt, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (2) tick();
            imem_ack = 1'b1;
            imem_rdata = 32'h0000_0013;
            tick();
            imem_ack = 1'b0;
            id_ready = 1'b1;
            tick();
            id_ready = 1'b0;
        end
        check("pc_instr", perf_instr_cnt, 32'd4);
        check("pc_stall", perf_stall_cnt, 32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
